// File: rtl/uart_fft_loader.sv
// Assembles LSB-first 16-bit samples from a UART byte stream into FFT input memory writes.
// A frame is HEADER followed by 2*N_POINTS data bytes; stalls between bytes abort the frame.
module uart_fft_loader #(
   parameter int unsigned N_POINTS = 8,
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [7:0]  HEADER   = 8'hA5
) (
   input  logic                        clk_uart,
   input  logic                        rst_n,
   input  logic [7:0]                  byte_i,
   input  logic                        byte_valid_i,
   input  logic                        fft_ready_i,
   output logic [15:0]                 sample_o,
   output logic [$clog2(N_POINTS)-1:0] sample_idx_o,
   output logic                        sample_we_o,
   output logic                        frame_done_o,
   output logic                        err_o,
   output logic                        busy_o
);

   localparam int unsigned IW = $clog2(N_POINTS);
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StLo, StHi, StWrite, StDone} state_t;

   state_t        state, next_state;
   logic [IW-1:0] idx, next_idx;
   logic [CW-1:0] tmo_cnt, next_tmo_cnt;
   logic [15:0]   sample, next_sample;

   always_ff @(posedge clk_uart) begin
      if (!rst_n) begin
         state   <= StIdle;
         idx     <= '0;
         tmo_cnt <= '0;
         sample  <= '0;
      end else begin
         state   <= next_state;
         idx     <= next_idx;
         tmo_cnt <= next_tmo_cnt;
         sample  <= next_sample;
      end
   end

   always_comb begin
      next_state   = state;
      next_idx     = idx;
      next_tmo_cnt = tmo_cnt;
      next_sample  = sample;
      sample_we_o  = 1'b0;
      frame_done_o = 1'b0;
      err_o        = 1'b0;

      case (state)
         StIdle: begin
            if (byte_valid_i && (byte_i == HEADER)) begin
               next_state   = StLo;
               next_tmo_cnt = '0;
            end
         end
         StLo, StHi: begin
            // A byte in the expiry cycle takes priority over the timeout.
            if (byte_valid_i) begin
               next_tmo_cnt = '0;
               if (state == StLo) begin
                  next_sample[7:0] = byte_i;
                  next_state       = StHi;
               end else begin
                  next_sample[15:8] = byte_i;
                  next_state        = StWrite;
               end
            end else if (tmo_cnt == LAST_CNT) begin
               err_o        = 1'b1;
               next_idx     = '0;
               next_tmo_cnt = '0;
               next_state   = StIdle;
            end else begin
               next_tmo_cnt = tmo_cnt + 1'b1;
            end
         end
         StWrite: begin
            if (byte_valid_i) begin
               err_o      = 1'b1;
               next_idx   = '0;
               next_state = StIdle;
            end else begin
               sample_we_o = 1'b1;
               if (fft_ready_i) begin
                  if (idx == LAST_IDX) begin
                     next_state = StDone;
                  end else begin
                     next_idx     = idx + 1'b1;
                     next_tmo_cnt = '0;
                     next_state   = StLo;
                  end
               end
            end
         end
         StDone: begin
            frame_done_o = 1'b1;
            next_idx     = '0;
            next_state   = StIdle;
         end
         default: begin
            next_idx   = '0;
            next_state = StIdle;
         end
      endcase
   end

   assign sample_o     = sample;
   assign sample_idx_o = idx;
   assign busy_o       = (state != StIdle);

endmodule

// File: tb/tb_uart_fft_loader.sv
// Self-checking bench: directed frames plus random byte/back-pressure traffic, compared each
// cycle against a byte-count based frame model.
`timescale 1ns/1ps
module tb_uart_fft_loader;

   localparam int NP  = 8;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        fft_ready;
   logic [15:0] sample;
   logic [2:0]  sample_idx;
   logic        sample_we;
   logic        frame_done;
   logic        err;
   logic        busy;

   uart_fft_loader #(
      .N_POINTS (NP),
      .TIMEOUT  (TMO),
      .HEADER   (8'hA5)
   ) dut (
      .clk_uart     (clk),
      .rst_n        (rst_n),
      .byte_i       (byte_in),
      .byte_valid_i (byte_valid),
      .fft_ready_i  (fft_ready),
      .sample_o     (sample),
      .sample_idx_o (sample_idx),
      .sample_we_o  (sample_we),
      .frame_done_o (frame_done),
      .err_o        (err),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: frame progress measured in data bytes received.
   bit          in_frame;
   bit          wr_pend;
   bit          done_pend;
   int          got;
   int          gap;
   logic [15:0] m_sample;

   // Observation counters for scenario-level checks.
   int cyc = 0;
   int n_done_seen = 0;
   int n_err_seen = 0;
   int n_wr_seen = 0;
   int last_err_cyc = -1;

   task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
      end
   endtask

   task automatic model_reset();
      in_frame  = 0;
      wr_pend   = 0;
      done_pend = 0;
      got       = 0;
      gap       = 0;
      m_sample  = '0;
   endtask

   task automatic step(input logic r, input logic bv, input logic [7:0] b, input logic rdy);
      logic e_we, e_err, e_done, e_busy;
      rst_n      = r;
      byte_valid = bv;
      byte_in    = b;
      fft_ready  = rdy;
      @(negedge clk);
      if (r) begin
         e_we   = 0;
         e_err  = 0;
         e_done = 0;
         e_busy = in_frame || done_pend;
         if (done_pend) e_done = 1;
         else if (wr_pend) begin
            if (bv) e_err = 1;
            else e_we = 1;
         end else if (in_frame && !bv && gap == TMO - 1) e_err = 1;
         check_eq("busy", 32'(busy), 32'(e_busy));
         check_eq("we", 32'(sample_we), 32'(e_we));
         check_eq("err", 32'(err), 32'(e_err));
         check_eq("frame_done", 32'(frame_done), 32'(e_done));
         check_eq("done_err_excl", 32'(frame_done & err), 32'd0);
         if (e_we) begin
            check_eq("sample", 32'(sample), 32'(m_sample));
            check_eq("idx", 32'(sample_idx), 32'(got / 2 - 1));
         end
         if (frame_done) n_done_seen++;
         if (err) begin
            n_err_seen++;
            last_err_cyc = cyc;
         end
         if (sample_we && rdy) n_wr_seen++;
      end
      @(posedge clk);
      if (!r) model_reset();
      else if (done_pend) done_pend = 0;
      else if (wr_pend) begin
         if (bv) begin
            in_frame = 0;
            wr_pend  = 0;
         end else if (rdy) begin
            wr_pend = 0;
            gap     = 0;
            if (got == 2 * NP) begin
               in_frame  = 0;
               done_pend = 1;
            end
         end
      end else if (in_frame) begin
         if (bv) begin
            if (got % 2 == 0) m_sample[7:0] = b;
            else m_sample[15:8] = b;
            got++;
            gap = 0;
            if (got % 2 == 0) wr_pend = 1;
         end else if (gap == TMO - 1) in_frame = 0;
         else gap++;
      end else if (bv && b == 8'hA5) begin
         in_frame = 1;
         got      = 0;
         gap      = 0;
      end
      cyc++;
      #1;
   endtask

   task automatic send_sample(input logic [7:0] lo, input logic [7:0] hi, input int stall);
      step(1, 1, lo, 1);
      step(1, 1, hi, 1);
      for (int i = 0; i < stall; i++) step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 8'h00, 1);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_sample", 32'(sample), 32'd0);
      check_eq("rst_idx", 32'(sample_idx), 32'd0);
      check_eq("rst_we", 32'(sample_we), 32'd0);
      check_eq("rst_done", 32'(frame_done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int d0, e0, w0, c34;
      model_reset();
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      check_reset_outputs();

      // Nominal frame with samples 1..8.
      d0 = n_done_seen; e0 = n_err_seen; w0 = n_wr_seen;
      step(1, 1, 8'hA5, 1);
      for (int k = 1; k <= NP; k++) send_sample(8'(k), 8'h00, 0);
      idle(2);
      check_eq("nominal_done_cnt", 32'(n_done_seen - d0), 32'd1);
      check_eq("nominal_err_cnt", 32'(n_err_seen - e0), 32'd0);
      check_eq("nominal_wr_cnt", 32'(n_wr_seen - w0), 32'd8);

      // Back-pressure on the third sample.
      d0 = n_done_seen; e0 = n_err_seen;
      step(1, 1, 8'hA5, 1);
      for (int k = 0; k < NP; k++) send_sample(8'(8'h10 + k), 8'h80, (k == 2) ? 5 : 0);
      idle(1);
      check_eq("bp_done_cnt", 32'(n_done_seen - d0), 32'd1);
      check_eq("bp_err_cnt", 32'(n_err_seen - e0), 32'd0);

      // Overflow: byte lands in the write cycle, then a clean frame.
      e0 = n_err_seen; d0 = n_done_seen;
      step(1, 1, 8'hA5, 1);
      step(1, 1, 8'h11, 0);
      step(1, 1, 8'h22, 0);
      step(1, 1, 8'h33, 0);
      step(1, 0, 8'h00, 1);
      check_eq("ovf_busy_after", 32'(busy), 32'd0);
      step(1, 1, 8'hA5, 1);
      for (int k = 0; k < NP; k++) send_sample(8'($urandom), 8'($urandom), 0);
      idle(1);
      check_eq("ovf_err_cnt", 32'(n_err_seen - e0), 32'd1);
      check_eq("ovf_done_cnt", 32'(n_done_seen - d0), 32'd1);

      // Timeout after A5 34.
      step(1, 1, 8'hA5, 1);
      c34 = cyc;
      step(1, 1, 8'h34, 1);
      last_err_cyc = -1;
      idle(20);
      check_eq("tmo_latency", 32'(last_err_cyc - c34), 32'd16);
      check_eq("tmo_idle", 32'(busy), 32'd0);

      // Byte on cycle 15, then one exactly at expiry: neither raises err.
      e0 = n_err_seen;
      step(1, 1, 8'hA5, 1);
      step(1, 1, 8'h34, 1);
      idle(14);
      step(1, 1, 8'h12, 1);
      idle(1);
      step(1, 1, 8'h56, 1);
      idle(15);
      step(1, 1, 8'h78, 1);
      check_eq("tmo_byte_wins", 32'(n_err_seen - e0), 32'd0);
      idle(1);
      step(0, 0, 8'h00, 0);

      // Resync with leading junk and A5 as data.
      d0 = n_done_seen;
      step(1, 1, 8'h00, 1);
      step(1, 1, 8'hFF, 1);
      step(1, 1, 8'hA5, 1);
      send_sample(8'hA5, 8'h12, 0);
      for (int k = 1; k < NP; k++) send_sample(8'hA5, 8'hA5, 0);
      idle(1);
      check_eq("resync_done_cnt", 32'(n_done_seen - d0), 32'd1);

      // Reset after three samples, mid-write.
      e0 = n_err_seen; d0 = n_done_seen;
      step(1, 1, 8'hA5, 1);
      for (int k = 0; k < 3; k++) send_sample(8'h44, 8'h01, 0);
      step(1, 1, 8'h55, 1);
      step(1, 1, 8'h66, 0);
      step(0, 0, 8'h00, 0);
      check_reset_outputs();
      step(1, 1, 8'hA5, 1);
      for (int k = 0; k < NP; k++) send_sample(8'(k), 8'hC0, 1);
      idle(1);
      check_eq("rst_err_cnt", 32'(n_err_seen - e0), 32'd0);
      check_eq("rst_done_cnt", 32'(n_done_seen - d0), 32'd1);

      // Random traffic with varying byte density and occasional reset.
      for (int seg = 0; seg < 40; seg++) begin
         int pv;
         pv = $urandom_range(100, 5);
         for (int i = 0; i < 80; i++) begin
            logic       r, bv, rdy;
            logic [7:0] b;
            r   = ($urandom_range(999) >= 5);
            bv  = ($urandom_range(99) < pv);
            b   = ($urandom_range(3) == 0) ? 8'hA5 : 8'($urandom);
            rdy = ($urandom_range(9) < 7);
            step(r, bv, b, rdy);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_fft_loader.md
UART_FFT_LOADER -- requirements
Module: uart_fft_loader

Interface
REQ-001 SHALL have parameter N_POINTS, default 8, meaning samples per FFT frame (power of two, 2..1024).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum clk_uart cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter HEADER, default 8'hA5, meaning the frame start byte.
REQ-004 clk_uart  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 byte_i  in  8  received UART byte; valid only while byte_valid_i=1.
REQ-007 byte_valid_i  in  1  one-cycle strobe, one per received byte.
REQ-008 fft_ready_i  in  1  FFT input memory accepts a write this cycle.
REQ-009 sample_o  out  16  assembled signed sample.
REQ-010 sample_idx_o  out  $clog2(N_POINTS)  write address of sample_o.
REQ-011 sample_we_o  out  1  write request; held until accepted.
REQ-012 frame_done_o  out  1  one-cycle pulse after the last sample of a frame is accepted.
REQ-013 err_o  out  1  one-cycle pulse on overflow or timeout abort.
REQ-014 busy_o  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, LO, HI, WRITE and DONE.
REQ-016 IDLE: on byte_valid_i with byte_i==HEADER, go to LO; other bytes are ignored silently.
REQ-017 LO: on byte_valid_i, latch byte_i as sample bits [7:0] and go to HI.
REQ-018 HI: on byte_valid_i, latch byte_i as bits [15:8] and go to WRITE; byte order is LSB first.
REQ-019 WRITE: drive sample_we_o=1 with sample_o and sample_idx_o held stable for as long as fft_ready_i=0.
REQ-020 A write is accepted in a cycle where sample_we_o=1 and fft_ready_i=1.
REQ-021 On acceptance, when idx<N_POINTS-1: increment idx and go to LO.
REQ-022 On acceptance, when idx==N_POINTS-1: go to DONE.
REQ-023 DONE: for one cycle, assert frame_done_o=1, clear idx to 0 and return to IDLE; a byte_valid_i in this cycle is dropped.
REQ-024 Write latency: sample_we_o rises in the cycle after the HI byte strobe.
REQ-025 Minimum write latency: with fft_ready_i=1, acceptance happens in the first sample_we_o cycle.
REQ-026 Overflow: byte_valid_i in WRITE SHALL pulse err_o, deassert sample_we_o, clear idx to 0, go to IDLE, and discard the byte.
REQ-027 Timeout counter: resets to 0 on every byte_valid_i and on entering LO; counts clk_uart cycles while in LO or HI.
REQ-028 When the counter reaches TIMEOUT-1 without a byte, SHALL pulse err_o, clear idx to 0 and go to IDLE.
REQ-029 If a byte arrives in the same cycle the timeout expires, the byte wins and no err_o is raised.
REQ-030 The timeout counter SHALL be frozen in WRITE, so back-pressure never causes a timeout.
REQ-031 A HEADER value arriving in LO or HI is treated as data, not as a resync.
REQ-032 idx SHALL never wrap inside a frame; it returns to 0 only via DONE, an abort or reset.
REQ-033 frame_done_o and err_o SHALL never be asserted in the same cycle.

Reset
REQ-034 While rst_n=0 at a clock edge: state=IDLE; idx, timeout counter and sample register =0.
REQ-035 While rst_n=0 at a clock edge: sample_o=0, sample_idx_o=0, sample_we_o=0, frame_done_o=0, err_o=0, busy_o=0.
REQ-036 Reset asserted mid-frame or mid-write SHALL abandon the frame with no err_o and no frame_done_o, including any pending write.

Verification
REQ-037 Nominal: N_POINTS=8, fft_ready_i=1; send A5 then 01 00 02 00 ... 08 00 -> 8 writes, idx 0..7, samples 0x0001..0x0008, one frame_done_o.
REQ-038 Back-pressure: fft_ready_i=0 for 5 cycles during sample 3 -> sample_we_o held with data and idx stable, then accepted; no err_o.
REQ-039 Overflow: fft_ready_i=0 and a new byte arrives in WRITE -> err_o pulse, busy_o=0 next cycle; a following A5 frame completes normally.
REQ-040 Timeout: TIMEOUT=16; stop after A5 34 -> err_o exactly 16 cycles after the 34 strobe, then IDLE; a byte arriving on cycle 15 -> no error.
REQ-041 Resync: send 00 FF A5 then 16 bytes -> the leading bytes are ignored and the frame is received correctly; A5 as a data byte yields sample 0x..A5.
REQ-042 Reset: rst_n=0 for 1 cycle after 3 samples -> all outputs 0; the next frame starts at idx 0.
